// File: rtl/regfile_pkg.sv
// Shared defaults, address type and read-bypass priority for the multi-port
// register file with load scoreboard.
package regfile_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;

    typedef logic [$clog2(NREGS_D)-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        SRC_ARRAY = 2'd0,
        SRC_WR0   = 2'd1,
        SRC_WR1   = 2'd2
    } byp_src_e;

    // Memory writeback is newest, so it outranks ALU writeback, which outranks the array.
    function automatic byp_src_e bypass_src(input logic hit1, input logic hit0);
        if (hit1) begin
            return SRC_WR1;
        end
        if (hit0) begin
            return SRC_WR0;
        end
        return SRC_ARRAY;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Load scoreboard: one busy bit per register plus a running count of set bits.
// A reservation and a memory writeback on the same register resolve to busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_D,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             wr1_en,
    input  logic [AW-1:0]    wr1_addr,
    output logic [NREGS-1:0] busy_vec,
    output logic [CW-1:0]    pend_cnt
);

    logic [NREGS-1:0] r_busy;
    logic [CW-1:0]    r_cnt;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_inc;
    logic             w_dec;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (rsv_en && (rsv_addr != '0)) begin
            w_set[rsv_addr] = 1'b1;
        end
        if (wr1_en && (wr1_addr != '0)) begin
            w_clr[wr1_addr] = 1'b1;
        end
    end

    // Count moves only on real transitions, so the count tracks popcount exactly.
    assign w_busy_nxt = (r_busy & ~w_clr) | w_set;
    assign w_inc      = |(w_set & ~r_busy);
    assign w_dec      = |(w_clr & r_busy & ~w_set);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= r_cnt + CW'(w_inc) - CW'(w_dec);
        end
    end

    assign busy_vec = r_busy;
    assign pend_cnt = r_cnt;

endmodule

// File: rtl/mp_regfile_sb.sv
// Multi-port integer register file: NRD bypassed read ports, ALU and memory
// write ports, and an integrated load scoreboard. Register 0 reads as zero.
module mp_regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_D,
    parameter  int NREGS = NREGS_D,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_ready,
    input  logic                     wr0_en,
    input  logic [AW-1:0]            wr0_addr,
    input  logic [XLEN-1:0]          wr0_data,
    input  logic                     wr1_en,
    input  logic [AW-1:0]            wr1_addr,
    input  logic [XLEN-1:0]          wr1_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    output logic [NREGS-1:0]         busy_vec,
    output logic [CW-1:0]            pend_cnt,
    output logic                     wr_conflict
);

    logic [XLEN-1:0]  r_mem [NREGS];
    logic             r_conflict;
    logic             w_we0;
    logic             w_we1;
    logic [NREGS-1:0] w_busy;

    assign w_we0 = wr0_en && (wr0_addr != '0);
    assign w_we1 = wr1_en && (wr1_addr != '0);

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_mem[r] <= '0;
            end
            r_conflict <= 1'b0;
        end else begin
            if (w_we0) begin
                r_mem[wr0_addr] <= wr0_data;
            end
            if (w_we1) begin
                r_mem[wr1_addr] <= wr1_data;
            end
            r_conflict <= w_we0 && w_we1 && (wr0_addr == wr1_addr);
        end
    end

    assign wr_conflict = r_conflict;

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .busy_vec (w_busy),
        .pend_cnt (pend_cnt)
    );

    assign busy_vec = w_busy;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        byp_src_e        w_src;
        logic [XLEN-1:0] w_data;
        logic            w_rdy;

        assign w_src = bypass_src(w_we1 && (wr1_addr == rd_addr[g]),
                                  w_we0 && (wr0_addr == rd_addr[g]));

        // A memory-writeback bypass always satisfies the reader; ALU data may still be shadowed by a pending load.
        always_comb begin
            w_data = '0;
            w_rdy  = 1'b0;
            if (!rst) begin
                if (rd_addr[g] == '0) begin
                    w_rdy = 1'b1;
                end else begin
                    case (w_src)
                        SRC_WR1: begin
                            w_data = wr1_data;
                            w_rdy  = 1'b1;
                        end
                        SRC_WR0: begin
                            w_data = wr0_data;
                            w_rdy  = !w_busy[rd_addr[g]];
                        end
                        default: begin
                            w_data = r_mem[rd_addr[g]];
                            w_rdy  = !w_busy[rd_addr[g]];
                        end
                    endcase
                end
            end
        end

        assign rd_data[g]  = w_data;
        assign rd_ready[g] = w_rdy;
    end

endmodule

// File: tb/tb_mp_regfile_sb.sv
// Bench for mp_regfile_sb: directed scenarios plus random traffic, all checked
// against an architectural model of registers and pending loads.
module tb_mp_regfile_sb;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = $clog2(NREGS);
    localparam int CW    = $clog2(NREGS + 1);

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_ready;
    logic                     wr0_en;
    reg_addr_t                wr0_addr;
    logic [XLEN-1:0]          wr0_data;
    logic                     wr1_en;
    reg_addr_t                wr1_addr;
    logic [XLEN-1:0]          wr1_data;
    logic                     rsv_en;
    reg_addr_t                rsv_addr;
    logic [NREGS-1:0]         busy_vec;
    logic [CW-1:0]            pend_cnt;
    logic                     wr_conflict;

    mp_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .wr0_en      (wr0_en),
        .wr0_addr    (wr0_addr),
        .wr0_data    (wr0_data),
        .wr1_en      (wr1_en),
        .wr1_addr    (wr1_addr),
        .wr1_data    (wr1_data),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .busy_vec    (busy_vec),
        .pend_cnt    (pend_cnt),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural state: register contents, set of outstanding loads, conflict flag.
    logic [XLEN-1:0]  m_mem [NREGS];
    logic [NREGS-1:0] m_busy;
    logic             m_conf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
            m_busy = '0;
            m_conf = 1'b0;
        end else begin
            m_conf = wr0_en && wr1_en && (wr0_addr == wr1_addr) && (wr1_addr != 0);
            if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
            if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
            if (wr1_en && wr1_addr != 0) m_busy[wr1_addr] = 1'b0;
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [XLEN-1:0] ed;
        logic            er;
        for (int p = 0; p < NRD; p++) begin
            if (rst) begin
                ed = '0; er = 1'b0;
            end else if (rd_addr[p] == 0) begin
                ed = '0; er = 1'b1;
            end else if (wr1_en && wr1_addr == rd_addr[p]) begin
                ed = wr1_data; er = 1'b1;
            end else if (wr0_en && wr0_addr == rd_addr[p]) begin
                ed = wr0_data; er = !m_busy[rd_addr[p]];
            end else begin
                ed = m_mem[rd_addr[p]]; er = !m_busy[rd_addr[p]];
            end
            chk($sformatf("rd_data[%0d]", p), 64'(rd_data[p]), 64'(ed));
            chk($sformatf("rd_ready[%0d]", p), 64'(rd_ready[p]), 64'(er));
        end
        chk("busy_vec", 64'(busy_vec), 64'(m_busy));
        chk("pend_cnt", 64'(pend_cnt), 64'($countones(m_busy)));
        chk("wr_conflict", 64'(wr_conflict), 64'(m_conf));
    endtask

    // Check mid-cycle, then advance model and DUT together; returns just after the edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    function automatic reg_addr_t rnd_addr();
        if ($urandom_range(0, 3) == 0) return reg_addr_t'($urandom_range(0, NREGS - 1));
        return reg_addr_t'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        rd_addr = '0;
        m_busy = '0;
        m_conf = 1'b0;
        @(posedge clk);
        model_clock();
        #1;

        // Reset then read
        idle();
        rd_addr[0] = AW'(5);
        rd_addr[1] = '0;
        #1;
        chk("rst_rd0", 64'(rd_data[0]), 64'(0));
        chk("rst_rdy0", 64'(rd_ready[0]), 64'(1));
        chk("rst_rdy1", 64'(rd_ready[1]), 64'(1));
        chk("rst_pend", 64'(pend_cnt), 64'(0));
        cycle();

        // Write x5, and a write to x0 that must vanish
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        cycle();
        idle();
        #1;
        chk("x5_rd", 64'(rd_data[0]), 64'(32'hDEADBEEF));
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h1234;
        cycle();
        idle();
        #1;
        chk("x0_rd", 64'(rd_data[1]), 64'(0));
        chk("x0_noconf", 64'(wr_conflict), 64'(0));

        // Dual write to x7
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h1111;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h2222;
        rd_addr[0] = AW'(7);
        #1;
        chk("cfl_byp", 64'(rd_data[0]), 64'(32'h2222));
        cycle();
        idle();
        #1;
        chk("cfl_arr", 64'(rd_data[0]), 64'(32'h2222));
        chk("cfl_flag", 64'(wr_conflict), 64'(1));
        cycle();
        chk("cfl_1cyc", 64'(wr_conflict), 64'(0));

        // Load scoreboard on x3
        rsv_en = 1'b1; rsv_addr = 5'd3;
        rd_addr[0] = AW'(3);
        #1;
        chk("rsv_pre_rdy", 64'(rd_ready[0]), 64'(1));
        cycle();
        idle();
        #1;
        chk("rsv_busy3", 64'(busy_vec[3]), 64'(1));
        chk("rsv_pend", 64'(pend_cnt), 64'(1));
        chk("rsv_rdy", 64'(rd_ready[0]), 64'(0));
        cycle();
        cycle();
        cycle();
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'hA5;
        #1;
        chk("ld_byp_rdy", 64'(rd_ready[0]), 64'(1));
        chk("ld_byp_data", 64'(rd_data[0]), 64'(32'hA5));
        cycle();
        idle();
        #1;
        chk("ld_busy3", 64'(busy_vec[3]), 64'(0));
        chk("ld_pend", 64'(pend_cnt), 64'(0));

        // Set/clear collision on x9
        rsv_en = 1'b1; rsv_addr = 5'd9;
        cycle();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99;
        cycle();
        idle();
        rd_addr[0] = AW'(9);
        #1;
        chk("col_busy9", 64'(busy_vec[9]), 64'(1));
        chk("col_pend", 64'(pend_cnt), 64'(1));
        chk("col_data", 64'(rd_data[0]), 64'(32'h99));
        chk("col_rdy", 64'(rd_ready[0]), 64'(0));
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h9A;
        cycle();

        // Reset while loads are outstanding
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd2; cycle();
        rsv_addr = 5'd4; cycle();
        rsv_addr = 5'd6; cycle();
        idle();
        #1;
        chk("mid_pend3", 64'(pend_cnt), 64'(3));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("mid_busy", 64'(busy_vec), 64'(0));
        chk("mid_pend0", 64'(pend_cnt), 64'(0));
        wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h44;
        cycle();
        idle();
        rd_addr[0] = AW'(4);
        #1;
        chk("mid_wr_pend", 64'(pend_cnt), 64'(0));
        chk("mid_wr_data", 64'(rd_data[0]), 64'(32'h44));
        chk("mid_wr_rdy", 64'(rd_ready[0]), 64'(1));

        // Random traffic biased toward a few registers to force hits and collisions
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            wr0_en   = 1'($urandom_range(0, 1));
            wr0_addr = rnd_addr();
            wr0_data = $urandom;
            wr1_en   = 1'($urandom_range(0, 1));
            wr1_addr = rnd_addr();
            wr1_data = $urandom;
            rsv_en   = 1'($urandom_range(0, 1));
            rsv_addr = rnd_addr();
            for (int p = 0; p < NRD; p++) rd_addr[p] = rnd_addr();
            cycle();
        end

        idle();
        cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mp_regfile_sb.md
# mp_regfile_sb

Parametrised multi-port integer register file with an integrated load scoreboard. It serves the decode/writeback boundary of the pipeline:
- NRD combinational read ports with same-cycle write bypass;
- two write ports: port 0 for ALU writeback, port 1 for memory writeback;
- per-register busy bits, set when a load issues and cleared when its data returns.

Register 0 is hardwired to zero and is never busy.

## Interface

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports
- AW, $clog2(NREGS), derived localparam, address width (not overridable)
- CW, $clog2(NREGS+1), derived localparam, pending-count width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- rd_addr  in  NRD×AW  read addresses
- rd_data  out  NRD×XLEN  read data, combinational
- rd_ready  out  NRD  read data is valid (register not pending, or bypassed this cycle)
- wr0_en  in  1  port 0 write enable
- wr0_addr  in  AW  port 0 address
- wr0_data  in  XLEN  port 0 data
- wr1_en  in  1  port 1 write enable; also clears the busy bit
- wr1_addr  in  AW  port 1 address
- wr1_data  in  XLEN  port 1 data
- rsv_en  in  1  reserve strobe: mark register pending (load issued)
- rsv_addr  in  AW  register to reserve
- busy_vec  out  NREGS  registered busy bits; bit 0 is always 0
- pend_cnt  out  CW  registered count of set busy bits
- wr_conflict  out  1  registered; 1 for one cycle after a same-address dual write

## Operation

Writes (posedge clk, rst low):
- Port 0 writes when wr0_en=1 and wr0_addr≠0.
- Port 1 writes when wr1_en=1 and wr1_addr≠0.
- Same nonzero address on both ports: wr1_data is stored, and wr_conflict=1 on the next cycle.
- Writes to address 0 are dropped silently and do not raise wr_conflict.

Reads (combinational, per port i), in priority order:
- If rst=1: rd_data=0 and rd_ready=0.
- Else if rd_addr=0: rd_data=0 and rd_ready=1.
- Else if wr1 hits the address: rd_data=wr1_data and rd_ready=1.
- Else if wr0 hits the address: rd_data=wr0_data, and rd_ready=!busy[addr].
- Else: rd_data=array[addr], and rd_ready=!busy[addr].

Scoreboard, next-state per register r≠0:
- Set when rsv_en and rsv_addr=r.
- Else cleared when wr1 is enabled and wr1_addr=r.
- Else held.

Scoreboard rules:
- Set and clear on the same register in the same cycle: set wins (a new load reserves it).
- Port 0 never clears busy.
- Reserving an already-busy register: it stays busy and pend_cnt is unchanged.
- rsv_addr=0 is ignored.

pend_cnt:
- Next value = current + (set of a non-busy register) − (clear of a busy register, unless the same register is being set).
- It always equals popcount(busy_vec).
- It never wraps: the maximum is NREGS−1.

Reset:
- On a posedge with rst=1, all registers, busy_vec, pend_cnt and wr_conflict go to 0.
- Writes and reservations presented in that cycle are discarded.
- Reset mid-load: outstanding reservations are lost. A later wr1 to such a register writes the data and leaves busy at 0.

## Timing

- Read latency is 0 cycles. Bypass makes a same-cycle writeback visible to readers.
- A write becomes visible from the array 1 cycle later.
- rsv_en in cycle N: busy_vec and rd_ready reflect it from cycle N+1. A reader of the same register in cycle N still sees rd_ready=1 (pre-reservation state).
- wr1 in cycle N: rd_ready=1 for that register in cycle N through bypass, and busy clears at N+1.
- All outputs other than rd_data and rd_ready are registered, with reset value 0.

## Structure

- Package regfile_pkg holds:
  - default localparams XLEN_D=32 and NREGS_D=32;
  - the typedef reg_addr_t;
  - the bypass-priority function (wr1 > wr0 > array).
- Sub-module regfile_scoreboard owns:
  - busy bits, pend_cnt and the set/clear arbitration;
  - inputs: clk, rst, rsv and wr1 controls;
  - outputs: busy_vec, pend_cnt.
- The top module holds the data array, write arbitration, NRD generate-loop read muxes and wr_conflict.

## Test plan

- Reset then read: after rst, all rd_data=0, all rd_ready=1, pend_cnt=0.
- Writes and x0: write x5=0xDEADBEEF via port 0. Next cycle port 0 reads 0xDEADBEEF. A write to x0 of 0x1234 still reads 0.
- Dual-write conflict: wr0 x7=0x1111 and wr1 x7=0x2222 in the same cycle. In that cycle, read x7 gives 0x2222 via bypass. Next cycle the array holds 0x2222 and wr_conflict=1 for exactly one cycle.
- Load scoreboard: rsv x3 in cycle N. At N+1, busy_vec[3]=1, pend_cnt=1, rd_ready=0 for x3. wr1 x3=0xA5 at N+4 gives rd_ready=1 and rd_data=0xA5 that cycle. At N+5, busy=0 and pend_cnt=0.
- Set/clear collision: x9 busy; rsv x9 and wr1 x9 in the same cycle. Next cycle busy_vec[9]=1, pend_cnt unchanged, and data updated.
- Reset mid-load: reserve x2, x4 and x6 (pend_cnt=3), then assert rst. Next cycle busy_vec=0 and pend_cnt=0. A following wr1 x4 keeps pend_cnt=0.
